vga_circle_scanner: RTL
=======================

// Module: vga_circle_scanner
// PURPOSE
//  Read side of the circle bitmap RAM. Generates 640x480@60 VGA timing on a 25 MHz pixel clock.
//  Upscales the WIDE x HIGH 1-bit bitmap by SCALE in both axes and drives the RAM read port
//  (rd_en/rd_addr/rd_data). Outputs 12-bit RGB with syncs aligned to the pixel data.
//  Sits between the bitmap RAM and the board VGA connector; idle until the RAM reports init_done.
// PARAMETERS
//  WIDE       213     bitmap width in pixels
//  HIGH       160     bitmap height in pixels
//  SCALE      3       integer upscale factor per axis (WIDE*SCALE <= 640, HIGH*SCALE <= 480)
//  READ_LAT   1       RAM read latency in cycles, rd_addr to rd_data (1 or 2)
//  FG_RGB     12'hFFF colour for a set bitmap pixel
//  BG_RGB     12'h000 colour for a clear bitmap pixel inside the image area
// PORTS
//  clk        in   1   25 MHz pixel clock
//  reset      in   1   asynchronous, active-high
//  init_done  in   1   bitmap RAM content valid
//  rd_en      out  1   RAM read enable
//  rd_addr    out  16  RAM read address, row*WIDE+col
//  rd_data    in   1   RAM read data, valid READ_LAT cycles after rd_addr/rd_en
//  hsync      out  1   horizontal sync, active-low
//  vsync      out  1   vertical sync, active-low
//  rgb        out  12  {R[3:0],G[3:0],B[3:0]}
//  frame_start out 1   one-cycle pulse when pixel (0,0) appears on rgb
// BEHAVIOUR
//  Reset: state=WAIT_INIT, h_cnt=v_cnt=0, rd_en=0, rd_addr=0, hsync=vsync=1, rgb=0, frame_start=0.
//  FSM WAIT_INIT: counters held at 0; syncs high; rgb=0; rd_en=0.
//    Transitions to SCAN on the first cycle init_done=1; SCAN begins at h=0, v=0.
//  FSM SCAN: h_cnt counts 0..799 and wraps; v_cnt increments on the h wrap, counts 0..524 and wraps.
//    If init_done=0 in SCAN, the next state is WAIT_INIT. In-flight pipeline data is discarded;
//    outputs are reset values from the next cycle.
//  Timing: active area h<640 and v<480.
//    hsync=0 for h in 656..751; vsync=0 for v in 490..491.
//  Image area: h<WIDE*SCALE (639) and v<HIGH*SCALE (480). Active pixels outside it show rgb=0.
//  Address generation uses no divider:
//    xsub counts 0..SCALE-1 and col increments on its wrap; both clear at h=0.
//    ysub increments at end of line; row_base+=WIDE on its wrap; all clear at v=0.
//    rd_addr=row_base+col (16 bit, max WIDE*HIGH-1=34079); rd_en=1 only in the image area.
//  Pipeline: h/v-derived signals (hsync, vsync, in_image, active) are delayed READ_LAT+1 stages.
//    rgb is registered, so counter-to-pin latency is READ_LAT+1 cycles for syncs and rgb alike.
//  rgb = !active ? 0 : !in_image ? 0 : rd_data ? FG_RGB : BG_RGB.
//  frame_start: asserted with the rgb of pixel (0,0) in every frame, not in WAIT_INIT.
//  Reset mid-frame: all state returns asynchronously to reset values; no partial frame is resumed.
// CONFIGURATION
//  FRAME_BORDER_EN defined:
//    Active pixels with h==0, h==639, v==0 or v==479 output 12'hF00, overriding the bitmap.
//    rd_en/rd_addr are unchanged.
//  FRAME_BORDER_EN undefined: no border; column 639 is black (outside image).
// TESTING
//  1 reset=1 then init_done=0 for 1000 cycles -> hsync=vsync=1, rgb=0, rd_en=0 throughout.
//  2 init_done=1 -> h_cnt=0 next cycle; hsync low for 96 cycles every 800 cycles;
//    vsync low for 1600 cycles every 420000 cycles.
//  3 Line v=0..2: rd_addr sequence 0,0,0,1,1,1,..,212 (639 reads) per line; line v=3 starts
//    at 213; line v=479 ends at 34079.
//  4 RAM model with bit 0 and bit 34079 set, rest 0 ->
//    rgb=FFF at pixels (0..2,0..2) and (636..638,477..479); else 000.
//    rgb lags the counters by READ_LAT+1 (checked with READ_LAT=1 and 2).
//  5 Drop init_done mid-line at h=300,v=100 -> next cycle syncs=1, rgb=0, rd_en=0.
//    Reassert -> frame_start one cycle after the first (0,0) pixel latency.
//  6 FRAME_BORDER_EN defined, all-zero RAM -> rgb=F00 on rows 0 and 479 and columns 0 and 639;
//    000 elsewhere in the active area.

Source files
------------

// File: rtl/vga_circle_scanner.sv
// Read side of the circle bitmap RAM: 640x480@60 VGA timing, SCALEx upscaled bitmap fetch, RGB out.
// Optional build macro FRAME_BORDER_EN paints a red one-pixel frame around the active area.
module vga_circle_scanner #(
  parameter int          WIDE     = 213,
  parameter int          HIGH     = 160,
  parameter int          SCALE    = 3,
  parameter int          READ_LAT = 1,
  parameter logic [11:0] FG_RGB   = 12'hFFF,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_done,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic        rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start
);

  typedef enum logic [0:0] {ST_WAIT = 1'b0, ST_SCAN = 1'b1} state_t;

  localparam int          SW         = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [9:0]  H_LAST     = 10'd799;
  localparam logic [9:0]  V_LAST     = 10'd524;
  localparam logic [9:0]  H_ACT      = 10'd640;
  localparam logic [9:0]  V_ACT      = 10'd480;
  localparam logic [9:0]  HS_BEG     = 10'd656;
  localparam logic [9:0]  HS_END     = 10'd751;
  localparam logic [9:0]  VS_BEG     = 10'd490;
  localparam logic [9:0]  VS_END     = 10'd491;
  localparam logic [9:0]  IMG_W      = 10'(WIDE * SCALE);
  localparam logic [9:0]  IMG_H      = 10'(HIGH * SCALE);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  localparam logic [15:0] WIDE16     = 16'(WIDE);

  // Pipeline stage bits: {first, border, active, in_image, vsync, hsync}
  localparam logic [5:0]  IDLE_STAGE = 6'b000011;

  state_t          state_q, state_d;
  logic [9:0]      h_q, h_d, v_q, v_d;
  logic [SW-1:0]   xsub_q, xsub_d, ysub_q, ysub_d;
  logic [15:0]     col_q, col_d, row_base_q, row_base_d;
  logic [5:0]      pipe_q [READ_LAT];
  logic [5:0]      pipe_d [READ_LAT];
  logic [5:0]      stage0_s, tail_s;
  logic            hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;
  logic [11:0]     rgb_q, rgb_d;
  logic            scan_s, active_s, in_image_s, border_s;

  // State machine and divider-free pixel/bitmap address counters
  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    v_d        = v_q;
    xsub_d     = xsub_q;
    ysub_d     = ysub_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    case (state_q)
      ST_WAIT: if (init_done) state_d = ST_SCAN; else state_d = ST_WAIT;
      ST_SCAN: if (!init_done) state_d = ST_WAIT; else state_d = ST_SCAN;
      default: state_d = ST_WAIT;
    endcase
    // Counters sit at zero outside SCAN so the first SCAN cycle is pixel (0,0).
    if ((state_q != ST_SCAN) || (state_d != ST_SCAN)) begin
      h_d        = 10'd0;
      v_d        = 10'd0;
      xsub_d     = '0;
      ysub_d     = '0;
      col_d      = 16'd0;
      row_base_d = 16'd0;
    end else if (h_q == H_LAST) begin
      h_d    = 10'd0;
      xsub_d = '0;
      col_d  = 16'd0;
      if (v_q == V_LAST) begin
        v_d        = 10'd0;
        ysub_d     = '0;
        row_base_d = 16'd0;
      end else begin
        v_d = v_q + 10'd1;
        if (ysub_q == SUB_LAST) begin
          ysub_d     = '0;
          row_base_d = row_base_q + WIDE16;
        end else begin
          ysub_d = ysub_q + SW'(1);
        end
      end
    end else begin
      h_d = h_q + 10'd1;
      if (xsub_q == SUB_LAST) begin
        xsub_d = '0;
        col_d  = col_q + 16'd1;
      end else begin
        xsub_d = xsub_q + SW'(1);
      end
    end
  end

  // Per-pixel attributes entering the pipeline
  always_comb begin
    scan_s     = (state_q == ST_SCAN);
    active_s   = (h_q < H_ACT) && (v_q < V_ACT);
    in_image_s = (h_q < IMG_W) && (v_q < IMG_H);
`ifdef FRAME_BORDER_EN
    border_s   = (h_q == 10'd0) || (h_q == H_ACT - 10'd1) || (v_q == 10'd0) || (v_q == V_ACT - 10'd1);
`else
    border_s   = 1'b0;
`endif
    if (scan_s) begin
      stage0_s = {(h_q == 10'd0) && (v_q == 10'd0), border_s, active_s, in_image_s,
                  !((v_q >= VS_BEG) && (v_q <= VS_END)), !((h_q >= HS_BEG) && (h_q <= HS_END))};
    end else begin
      stage0_s = IDLE_STAGE;
    end
  end

  assign rd_en   = scan_s && in_image_s;
  assign rd_addr = row_base_q + col_q;
  assign tail_s  = pipe_q[READ_LAT-1];

  // Delay line aligned with RAM latency, then the registered pixel colour
  always_comb begin
    for (int i = 0; i < READ_LAT; i++) pipe_d[i] = IDLE_STAGE;
    hsync_d = 1'b1;
    vsync_d = 1'b1;
    fs_d    = 1'b0;
    rgb_d   = 12'h000;
    // Leaving SCAN discards everything in flight.
    if (state_d == ST_SCAN) begin
      pipe_d[0] = stage0_s;
      for (int i = 1; i < READ_LAT; i++) pipe_d[i] = pipe_q[i-1];
      hsync_d = tail_s[0];
      vsync_d = tail_s[1];
      fs_d    = tail_s[5];
      if (!tail_s[3]) begin
        rgb_d = 12'h000;
      end else if (tail_s[4]) begin
        rgb_d = 12'hF00;
      end else if (!tail_s[2]) begin
        rgb_d = 12'h000;
      end else if (rd_data) begin
        rgb_d = FG_RGB;
      end else begin
        rgb_d = BG_RGB;
      end
    end else begin
      hsync_d = 1'b1;
    end
  end

  // State, counters, pipeline and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_WAIT;
      h_q        <= 10'd0;
      v_q        <= 10'd0;
      xsub_q     <= '0;
      ysub_q     <= '0;
      col_q      <= 16'd0;
      row_base_q <= 16'd0;
      pipe_q     <= '{default: IDLE_STAGE};
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      fs_q       <= 1'b0;
      rgb_q      <= 12'h000;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      xsub_q     <= xsub_d;
      ysub_q     <= ysub_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      pipe_q     <= pipe_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      fs_q       <= fs_d;
      rgb_q      <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule
